blur_scheduler: RTL and testbench

//  Sequences the 5x5 blur datapath over a whole image, one 16-pixel strip at a time.
//  Per anchor: fetch 20 input pixels (req/ack), pulse anchor_moving, wait blur_final,

---
 rtl/edge_pkg.sv | 28 ++
 rtl/flex_counter.sv | 60 ++++++
 rtl/blur_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_blur_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Definitions shared by the filter schedulers: the scheduler state
// enumeration, default counter widths and a saturating-increment helper.
// No ports.
// ---------------------------------------------------------------------------
package edge_pkg;

  localparam int SCHED_ROW_BITS   = 16;
  localparam int SCHED_STRIP_BITS = 12;
  localparam int SCHED_ANCHOR_W   = 32;

  typedef enum logic [2:0] {
    SCHED_IDLE    = 3'd0,
    SCHED_FETCH   = 3'd1,
    SCHED_LAUNCH  = 3'd2,
    SCHED_RUN     = 3'd3,
    SCHED_WRITE   = 3'd4,
    SCHED_ADVANCE = 3'd5,
    SCHED_FINISH  = 3'd6
  } sched_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Up-counter with a run-time rollover value: after reaching rollover_val_i,
// the next enabled count returns it to zero.
// Ports:
//   clk             in  clock
//   n_rst           in  async active-low reset
//   clear_i         in  synchronous clear to zero (wins over enable)
//   count_enable_i  in  advance the count by one
//   rollover_val_i  in  last value before wrapping to zero
//   count_out_o     out current count (registered)
//   rollover_flag_o out high while count equals rollover_val_i
// ---------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_out_o,
  output logic                    rollover_flag_o
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;
  logic                    at_roll_s;

  assign at_roll_s = (count_q == rollover_val_i);

  // Next count: clear, wrap, step or hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      if (at_roll_s) begin
        count_d = '0;
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out_o     = count_q;
  assign rollover_flag_o = at_roll_s;

endmodule

// File: rtl/blur_scheduler.sv
// ---------------------------------------------------------------------------
// blur_scheduler
// Walks the 5x5 blur datapath over a frame one anchor at a time: fetch the
// input window, launch the blur, wait for completion, write the strip back,
// then step to the next row (and to the next strip after the last row).
// Optional build macro: PERF_CNT_EN adds a stall-cycle counter on perf_stall;
// without it perf_stall is constant zero.
// Ports:
//   clk, n_rst            clock, async active-low reset
//   start / abort         frame start pulse (ignored while busy) / cancel level
//   cfg_rows, cfg_strips  frame geometry, captured on an accepted start
//   fetch_req / fetch_ack window read handshake
//   anchor_moving         one-cycle launch pulse to the blur controller
//   anchor_x, anchor_y    current row / strip index, zero-extended to 32 bits
//   blur_final            blur pass complete
//   wb_req / wb_ack       write-back handshake
//   busy, done            frame in progress / one-cycle completion pulse
//   perf_stall            cycles spent waiting for fetch_ack or wb_ack
// ---------------------------------------------------------------------------
module blur_scheduler
  import edge_pkg::*;
#(
  parameter int ROW_BITS   = SCHED_ROW_BITS,
  parameter int STRIP_BITS = SCHED_STRIP_BITS
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ROW_BITS-1:0]       cfg_rows,
  input  logic [STRIP_BITS-1:0]     cfg_strips,
  output logic                      fetch_req,
  input  logic                      fetch_ack,
  output logic                      anchor_moving,
  output logic [SCHED_ANCHOR_W-1:0] anchor_x,
  output logic [SCHED_ANCHOR_W-1:0] anchor_y,
  input  logic                      blur_final,
  output logic                      wb_req,
  input  logic                      wb_ack,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               perf_stall
);

  sched_state_t          state_q;
  logic [ROW_BITS-1:0]   rows_m1_q;
  logic [STRIP_BITS-1:0] strips_m1_q;
  logic [STRIP_BITS-1:0] y_q;
  logic                  fetch_req_q;
  logic                  wb_req_q;
  logic                  moving_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  start_ok_s;
  logic                  x_en_s;
  logic                  x_wrap_s;
  logic                  last_s;
  logic [ROW_BITS-1:0]   x_cnt_s;

  // busy_q is still high in IDLE during the cycle after done, so a start there
  // is treated as arriving while busy.
  assign start_ok_s = (state_q == SCHED_IDLE) && !busy_q && start && !abort;
  assign x_en_s     = (state_q == SCHED_ADVANCE) && !abort;
  assign last_s     = x_wrap_s && (y_q == strips_m1_q);

  flex_counter #(
    .NUM_CNT_BITS (ROW_BITS)
  ) u_row_cnt (
    .clk             (clk),
    .n_rst           (n_rst),
    .clear_i         (start_ok_s),
    .count_enable_i  (x_en_s),
    .rollover_val_i  (rows_m1_q),
    .count_out_o     (x_cnt_s),
    .rollover_flag_o (x_wrap_s)
  );

  // Frame sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= SCHED_IDLE;
      rows_m1_q   <= '0;
      strips_m1_q <= '0;
      y_q         <= '0;
      fetch_req_q <= 1'b0;
      wb_req_q    <= 1'b0;
      moving_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= SCHED_IDLE;
      fetch_req_q <= 1'b0;
      wb_req_q    <= 1'b0;
      moving_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      moving_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        SCHED_IDLE: begin
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            rows_m1_q   <= cfg_rows - ROW_BITS'(1);
            strips_m1_q <= cfg_strips - STRIP_BITS'(1);
            y_q         <= '0;
            busy_q      <= 1'b1;
            if ((cfg_rows == '0) || (cfg_strips == '0)) begin
              state_q <= SCHED_FINISH;
            end else begin
              state_q     <= SCHED_FETCH;
              fetch_req_q <= 1'b1;
            end
          end
        end
        SCHED_FETCH: begin
          if (fetch_ack) begin
            fetch_req_q <= 1'b0;
            moving_q    <= 1'b1;
            state_q     <= SCHED_LAUNCH;
          end
        end
        SCHED_LAUNCH: begin
          state_q <= SCHED_RUN;
        end
        SCHED_RUN: begin
          if (blur_final) begin
            wb_req_q <= 1'b1;
            state_q  <= SCHED_WRITE;
          end
        end
        SCHED_WRITE: begin
          if (wb_ack) begin
            wb_req_q <= 1'b0;
            state_q  <= SCHED_ADVANCE;
          end
        end
        SCHED_ADVANCE: begin
          // The row counter steps on this same edge; the strip index only
          // moves when the row wraps and this is not the final anchor.
          if (last_s) begin
            state_q <= SCHED_FINISH;
          end else begin
            if (x_wrap_s) begin
              y_q <= y_q + STRIP_BITS'(1);
            end
            fetch_req_q <= 1'b1;
            state_q     <= SCHED_FETCH;
          end
        end
        SCHED_FINISH: begin
          done_q  <= 1'b1;
          state_q <= SCHED_IDLE;
        end
        default: begin
          fetch_req_q <= 1'b0;
          wb_req_q    <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= SCHED_IDLE;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Stall count: reset on an accepted start, bump while a request waits.
  always_comb begin
    perf_d = perf_q;
    if (start_ok_s) begin
      perf_d = 32'd0;
    end else if (((state_q == SCHED_FETCH) && !fetch_ack) ||
                 ((state_q == SCHED_WRITE) && !wb_ack)) begin
      perf_d = sat_inc32(perf_q);
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = 32'd0;
`endif

  assign fetch_req     = fetch_req_q;
  assign wb_req        = wb_req_q;
  assign anchor_moving = moving_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign anchor_x      = SCHED_ANCHOR_W'(x_cnt_s);
  assign anchor_y      = SCHED_ANCHOR_W'(y_q);

endmodule

// File: tb/tb_blur_scheduler.sv
// ---------------------------------------------------------------------------
// tb_blur_scheduler
// Drives blur_scheduler with randomized handshake latencies and compares the
// observed anchor sequence, handshake counts and status against a row-major
// frame walk computed from the frame geometry.
// ---------------------------------------------------------------------------
module tb_blur_scheduler;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_rows;
  logic [11:0] cfg_strips;
  logic        fetch_req;
  logic        fetch_ack;
  logic        anchor_moving;
  logic [31:0] anchor_x;
  logic [31:0] anchor_y;
  logic        blur_final;
  logic        wb_req;
  logic        wb_ack;
  logic        busy;
  logic        done;
  logic [31:0] perf_stall;

  blur_scheduler dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .abort         (abort),
    .cfg_rows      (cfg_rows),
    .cfg_strips    (cfg_strips),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .anchor_moving (anchor_moving),
    .anchor_x      (anchor_x),
    .anchor_y      (anchor_y),
    .blur_final    (blur_final),
    .wb_req        (wb_req),
    .wb_ack        (wb_ack),
    .busy          (busy),
    .done          (done),
    .perf_stall    (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs: a value >= 0 fixes the latency, -1 randomizes it.
  int f_fix, w_fix, r_fix;
  bit spur_en;

  int  f_cnt, f_dly, w_cnt, w_dly, r_cnt, r_dly;
  bit  f_arm, w_arm, r_act;
  longint exp_stall;

  int  n_fetch, n_wb, n_done, n_freq_hi, n_seq_err;
  bit  prev_freq, prev_wreq, prev_am;
  logic [31:0] lq_x[$];
  logic [31:0] lq_y[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Observer and responder for the DUT's handshakes, all at the falling edge.
  initial begin
    fetch_ack = 1'b0; wb_ack = 1'b0; blur_final = 1'b0;
    f_arm = 1'b0; w_arm = 1'b0; r_act = 1'b0;
    f_cnt = 0; w_cnt = 0; r_cnt = 0; f_dly = 0; w_dly = 0; r_dly = 1;
    prev_freq = 1'b0; prev_wreq = 1'b0; prev_am = 1'b0;
    forever begin
      @(negedge clk);
      // A launch must follow an accepted fetch and last a single cycle.
      if (anchor_moving) begin
        lq_x.push_back(anchor_x);
        lq_y.push_back(anchor_y);
        if (!fetch_ack || prev_am) n_seq_err++;
      end
      if (fetch_req && !prev_freq) n_fetch++;
      if (fetch_req) n_freq_hi++;
      // The write-back must target the anchor that was launched.
      if (wb_req && !prev_wreq) begin
        n_wb++;
        if (lq_x.size() == 0) n_seq_err++;
        else if (anchor_x != lq_x[$] || anchor_y != lq_y[$]) n_seq_err++;
      end
      if (done) n_done++;
      prev_freq = fetch_req; prev_wreq = wb_req; prev_am = anchor_moving;

      if (fetch_req) begin
        if (!f_arm) begin
          f_arm = 1'b1; f_cnt = 0;
          f_dly = (f_fix >= 0) ? f_fix : int'($urandom_range(0, 3));
          exp_stall += f_dly;
        end
        if (f_cnt == f_dly) fetch_ack = 1'b1;
        else begin fetch_ack = 1'b0; f_cnt++; end
      end else begin
        f_arm = 1'b0;
        fetch_ack = spur_en && ($urandom_range(0, 5) == 0);
      end

      if (wb_req) begin
        if (!w_arm) begin
          w_arm = 1'b1; w_cnt = 0;
          w_dly = (w_fix >= 0) ? w_fix : int'($urandom_range(0, 3));
          exp_stall += w_dly;
        end
        if (w_cnt == w_dly) wb_ack = 1'b1;
        else begin wb_ack = 1'b0; w_cnt++; end
      end else begin
        w_arm = 1'b0;
        wb_ack = spur_en && ($urandom_range(0, 5) == 0);
      end

      if (anchor_moving) begin
        r_act = 1'b1; r_cnt = 0; blur_final = 1'b0;
        r_dly = (r_fix >= 1) ? r_fix : int'($urandom_range(1, 6));
      end else if (r_act) begin
        r_cnt++;
        if (r_cnt >= r_dly) begin blur_final = 1'b1; r_act = 1'b0; end
        else blur_final = 1'b0;
      end else begin
        blur_final = spur_en && ($urandom_range(0, 5) == 0);
      end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    n_fetch = 0; n_wb = 0; n_done = 0; n_freq_hi = 0; n_seq_err = 0;
    exp_stall = 0;
    lq_x.delete(); lq_y.delete();
  endtask

  task automatic begin_frame(input int r, input int s);
    clear_mon();
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'(r); cfg_strips = 12'(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (n_done == 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Expected walk: strips outer, rows inner, each anchor visited once.
  task automatic verify_frame(input int r, input int s, input string tag);
    int k;
    k = 0;
    check({tag, "_launches"}, lq_x.size(), r * s);
    for (int y = 0; y < s; y++) begin
      for (int x = 0; x < r; x++) begin
        if (k < lq_x.size()) begin
          check({tag, "_anchor_x"}, lq_x[k], x);
          check({tag, "_anchor_y"}, lq_y[k], y);
        end
        k++;
      end
    end
    check({tag, "_fetches"}, n_fetch, r * s);
    check({tag, "_writes"}, n_wb, r * s);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_seq_errors"}, n_seq_err, 0);
`ifdef PERF_CNT_EN
    check({tag, "_perf_stall"}, perf_stall, exp_stall);
`else
    check({tag, "_perf_stall"}, perf_stall, 0);
`endif
  endtask

  task automatic run_frame(input int r, input int s, input string tag);
    begin_frame(r, s);
    wait_done(2000);
    verify_frame(r, s, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_rows = 16'd0; cfg_strips = 12'd0;
    f_fix = -1; w_fix = -1; r_fix = -1; spur_en = 1'b0;
    exp_stall = 0;
    #1;
    check("rst_fetch_req", fetch_req, 1'b0);
    check("rst_wb_req", wb_req, 1'b0);
    check("rst_moving", anchor_moving, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_anchor_x", anchor_x, 0);
    check("rst_anchor_y", anchor_y, 0);
    check("rst_perf", perf_stall, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    // Zero-wait acks, fixed blur latency.
    f_fix = 0; w_fix = 0; r_fix = 4; spur_en = 1'b1;
    run_frame(3, 2, "basic");

    // Slow fetch: five wait cycles, then the ack cycle.
    f_fix = 5; w_fix = 0; r_fix = 2; spur_en = 1'b0;
    run_frame(1, 1, "fetch_wait");
    check("fetch_wait_req_cycles", n_freq_hi, 6);
`ifdef PERF_CNT_EN
    check("fetch_wait_perf5", perf_stall, 5);
`endif

    // Empty geometry finishes without any fetch.
    f_fix = -1; w_fix = -1; r_fix = -1; spur_en = 1'b1;
    clear_mon();
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'd0; cfg_strips = 12'd4;
    @(posedge clk); #1;
    check("zero_c1_busy", busy, 1'b1);
    check("zero_c1_done", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("zero_c2_done", done, 1'b1);
    @(posedge clk); #1;
    check("zero_c3_done", done, 1'b0);
    check("zero_c3_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_fetches", n_fetch, 0);
    check("zero_done_pulses", n_done, 1);
    run_frame(3, 0, "zero_strips");

    // Abort while running the second anchor.
    f_fix = 0; w_fix = 0; r_fix = 10;
    begin_frame(3, 2);
    for (int c = 0; c < 200 && lq_x.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    check("abort_launches_before", lq_x.size(), 2);
    if (lq_x.size() >= 2) begin
      check("abort_anchor_x", lq_x[1], 1);
      check("abort_anchor_y", lq_y[1], 0);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_fetch_req", fetch_req, 1'b0);
    check("abort_wb_req", wb_req, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_writes", n_wb, 1);
    check("abort_wb_req_late", wb_req, 1'b0);

    // Start and abort together: request is dropped.
    clear_mon();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_rows = 16'd2; cfg_strips = 12'd2;
    @(posedge clk); #1;
    check("sa_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sa_fetches", n_fetch, 0);

    // A second start mid-frame must not change the geometry.
    f_fix = -1; w_fix = -1; r_fix = -1;
    begin_frame(2, 2);
    repeat (8) @(posedge clk);
    #1;
    check("restart_busy_mid", busy, 1'b1);
    @(negedge clk);
    start = 1'b1; cfg_rows = 16'd5; cfg_strips = 12'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    verify_frame(2, 2, "restart");

    // Single-anchor frame.
    run_frame(1, 1, "single");

    // Randomized geometries and latencies.
    for (int i = 0; i < 5; i++) begin
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), "rand");
    end

    // Reset while a write-back is pending.
    w_fix = 50;
    begin_frame(2, 1);
    for (int c = 0; c < 200 && wb_req !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    check("rstw_wb_req_seen", wb_req, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("rstw_wb_req", wb_req, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_fetch_req", fetch_req, 1'b0);
    check("rstw_moving", anchor_moving, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_anchor_x", anchor_x, 0);
    check("rstw_anchor_y", anchor_y, 0);
    check("rstw_perf", perf_stall, 0);
    @(negedge clk);
    n_rst = 1'b1;
    w_fix = -1;
    run_frame(2, 3, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
